// File: rtl/alu_serial_unit.sv
// alu_serial_unit: bit-serial add/subtract/compare/AND unit with a
// valid/ready command and response handshake. One operand bit is processed
// per cycle, LSB first.
// Optional feature: define ALU_SERIAL_OPCOUNT_EN to add the op_count output,
// a wrapping 8-bit count of completed (handed-off) responses.
module alu_serial_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] RESULT,
  output logic             carry,
  output logic             borrow,
  output logic [2:0]       COMPARE
`ifdef ALU_SERIAL_OPCOUNT_EN
  ,
  output logic [7:0]       op_count
`endif
);

  // Counter runs 0..WIDTH-1 over the operand bits; the value WIDTH marks the
  // commit cycle that loads the output registers on entry to DONE.
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_sh_q, res_sh_d;
  logic               chain_q, chain_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic [2:0]         compare_q, compare_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
`ifdef ALU_SERIAL_OPCOUNT_EN
  logic [7:0]         op_count_q, op_count_d;
`endif

  logic a_bit, b_bit, b_eff, sum_bit, cout, res_bit;

  // Single-bit slice: full adder (B inverted for subtract) and per-op result bit.
  always_comb begin
    a_bit   = a_sh_q[0];
    b_bit   = b_sh_q[0];
    b_eff   = (op_q == OP_SUB) ? ~b_bit : b_bit;
    sum_bit = a_bit ^ b_eff ^ chain_q;
    cout    = (a_bit & b_eff) | (a_bit & chain_q) | (b_eff & chain_q);
    res_bit = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: res_bit = sum_bit;
      OP_AND:         res_bit = a_bit & b_bit;
      default:        res_bit = 1'b0;
    endcase
  end

  // Next-state and datapath updates for the IDLE/EXEC/DONE sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    chain_d   = chain_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    result_d  = result_q;
    carry_d   = carry_q;
    borrow_d  = borrow_q;
    compare_d = compare_q;
`ifdef ALU_SERIAL_OPCOUNT_EN
    op_count_d = op_count_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d  = EXEC;
          cnt_d    = '0;
          op_d     = S;
          a_sh_d   = A;
          b_sh_d   = B;
          res_sh_d = '0;
          chain_d  = (S == OP_SUB);
          gt_d     = 1'b0;
          lt_d     = 1'b0;
        end
      end
      EXEC: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d   = DONE;
          cnt_d     = '0;
          result_d  = (op_q == OP_CMP) ? '0 : res_sh_q;
          carry_d   = (op_q == OP_ADD) & chain_q;
          borrow_d  = (op_q == OP_SUB) & ~chain_q;
          compare_d = (op_q == OP_CMP) ? {gt_q, ~(gt_q | lt_q), lt_q} : 3'b000;
        end else begin
          a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
          res_sh_d = {res_bit, res_sh_q[WIDTH-1:1]};
          chain_d  = cout;
          // Later (more significant) differing bits overwrite earlier ones.
          if (a_bit != b_bit) begin
            gt_d = a_bit;
            lt_d = ~a_bit;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef ALU_SERIAL_OPCOUNT_EN
    if (rsp_valid_q && rsp_ready) begin
      op_count_d = op_count_q + 8'd1;
    end
`endif

    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      chain_q     <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      compare_q   <= 3'b000;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
`ifdef ALU_SERIAL_OPCOUNT_EN
      op_count_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      chain_q     <= chain_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      compare_q   <= compare_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef ALU_SERIAL_OPCOUNT_EN
      op_count_q  <= op_count_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign RESULT    = result_q;
  assign carry     = carry_q;
  assign borrow    = borrow_q;
  assign COMPARE   = compare_q;
`ifdef ALU_SERIAL_OPCOUNT_EN
  assign op_count  = op_count_q;
`endif

endmodule

// File: doc/alu_serial_unit.md
ALU_SERIAL_UNIT -- requirements
Module: alu_serial_unit

Interface
REQ-001 Parameter WIDTH, default 4: operand/result width in bits; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  unit can accept a command.
REQ-006 S  input  2  op select: 00 add, 01 subtract, 10 compare, 11 bitwise AND.
REQ-007 A  input  WIDTH  operand A, unsigned.
REQ-008 B  input  WIDTH  operand B, unsigned.
REQ-009 rsp_valid  output  1  result present.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 RESULT  output  WIDTH  sum, difference or AND, per op.
REQ-012 carry  output  1  add carry-out.
REQ-013 borrow  output  1  subtract borrow-out.
REQ-014 COMPARE  output  3  {A>B, A==B, A<B}, one-hot.

Function
REQ-015 FSM states IDLE, EXEC, DONE; cmd_ready SHALL be 1 only in IDLE, rsp_valid only in DONE.
REQ-016 IDLE->EXEC on cmd_valid&cmd_ready; S, A, B latched at that edge; later input changes ignored.
REQ-017 EXEC processes one bit per cycle, LSB first, for exactly WIDTH cycles via bit counter 0..WIDTH-1, then ->DONE.
REQ-018 Latency: handshake at edge T -> rsp_valid first high after edge T+WIDTH+1 (T+5 for WIDTH=4).
REQ-019 Add: RESULT=(A+B) mod 2^WIDTH, carry=bit WIDTH of A+B; borrow=0, COMPARE=000.
REQ-020 Subtract: A+~B+1 serially; RESULT=(A-B) mod 2^WIDTH; borrow=1 iff A<B; carry=0, COMPARE=000.
REQ-021 Compare: at each bit with A[i]!=B[i], gt<=A[i], lt<=~A[i] (MSB decides); eq iff no bit differs; RESULT=0, carry=0, borrow=0.
REQ-022 AND: RESULT=A&B; carry=0, borrow=0, COMPARE=000.
REQ-023 In DONE, RESULT/carry/borrow/COMPARE and rsp_valid SHALL hold stable until rsp_valid&rsp_ready.
REQ-024 DONE->IDLE on rsp_ready; cmd_ready high the next cycle; no same-cycle command acceptance in DONE.
REQ-025 Outputs RESULT, carry, borrow, COMPARE SHALL retain last result in IDLE/EXEC until overwritten at entry to DONE.
REQ-026 cmd_valid while not IDLE SHALL be ignored (no queueing).

Reset
REQ-027 rst at any edge, including mid-EXEC or in DONE: state->IDLE, bit counter=0, rsp_valid=0, cmd_ready=1 after the edge, in-flight op discarded.
REQ-028 Reset values: RESULT=0, carry=0, borrow=0, COMPARE=000; rst has priority over every handshake.

Configuration
REQ-029 Macro ALU_SERIAL_OPCOUNT_EN defined: adds output op_count [7:0], increments once per rsp_valid&rsp_ready, wraps 255->0, reset to 0, discarded ops not counted.
REQ-030 Macro undefined: op_count port and counter absent; all other behaviour identical.

Verification
REQ-031 A=0110,B=0010, S=00,01,10,11 in turn -> RESULT 1000 c0 / 0100 b0 / COMPARE 100 / RESULT 0010; each rsp_valid exactly 5 cycles after accept.
REQ-032 A=1111,B=0001,S=00 -> RESULT 0000, carry 1; A=0010,B=0011,S=01 -> RESULT 1111, borrow 1; A=B=0011,S=10 -> COMPARE 010.
REQ-033 rsp_ready held 0 for 10 cycles in DONE -> outputs and rsp_valid stable; cmd_ready 0; accept then cmd_ready 1 next cycle.
REQ-034 A/B/S changed and cmd_valid pulsed during EXEC -> result reflects latched command; extra command dropped.
REQ-035 rst asserted at EXEC bit 2 -> next cycle IDLE, cmd_ready 1, rsp_valid 0, outputs zero; new command completes normally.
REQ-036 With ALU_SERIAL_OPCOUNT_EN: 257 completed ops -> op_count=1; reset mid-op not counted.
